// File: rtl/time_set_ctrl.sv
// Mode and time-setting controller: button conditioning, RUN/SET_HR/SET_MIN sequencing,
// hold-to-accelerate auto-repeat. Optional set-mode timeout under `TIME_SET_TIMEOUT_EN.
module time_set_ctrl #(
  parameter int HOLD_FAST  = 2,
  parameter int HOLD_VFAST = 4,
  parameter int TIMEOUT    = 30
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pulse_vf,
  input  logic       i_pulse_f,
  input  logic       i_pulse_n,
  input  logic       i_btn_mode,
  input  logic       i_btn_adv,
  output logic       o_tick_sec,
  output logic       o_inc_hr,
  output logic       o_inc_min,
  output logic       o_sec_clr,
  output logic [1:0] o_mode,
  output logic       o_blink
);

  // state      | meaning
  // ST_RUN     | normal timekeeping, seconds tick, ADV ignored
  // ST_SET_HR  | hours field adjustable, seconds keep ticking
  // ST_SET_MIN | minutes field adjustable, seconds frozen
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  localparam int HW = $clog2(HOLD_VFAST + 1);

  logic [1:0]    r_mode_sync, r_adv_sync;
  logic          r_mode_prev, r_adv_prev;
  logic          r_mode_db, r_adv_db;
  logic          r_mode_db_d, r_adv_db_d;
  state_t        r_state, w_next;
  logic [HW-1:0] r_hold;
  logic          r_hold_en;
  logic          r_tick, r_inc_hr, r_inc_min, r_sec_clr, r_blink;
  logic          w_mode_press, w_adv_press, w_adv_rel, w_set, w_timeout, w_inc;

  // Debounced level only moves when two successive fast-strobe samples agree.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_mode_sync <= '0;
      r_adv_sync  <= '0;
      r_mode_prev <= 1'b0;
      r_adv_prev  <= 1'b0;
      r_mode_db   <= 1'b0;
      r_adv_db    <= 1'b0;
      r_mode_db_d <= 1'b0;
      r_adv_db_d  <= 1'b0;
    end else begin
      r_mode_sync <= {r_mode_sync[0], i_btn_mode};
      r_adv_sync  <= {r_adv_sync[0], i_btn_adv};
      r_mode_db_d <= r_mode_db;
      r_adv_db_d  <= r_adv_db;
      if (i_pulse_f) begin
        r_mode_prev <= r_mode_sync[1];
        r_adv_prev  <= r_adv_sync[1];
        if (r_mode_sync[1] == r_mode_prev) r_mode_db <= r_mode_sync[1];
        if (r_adv_sync[1] == r_adv_prev)   r_adv_db  <= r_adv_sync[1];
      end
    end
  end

  assign w_mode_press = r_mode_db & ~r_mode_db_d;
  assign w_adv_press  = r_adv_db & ~r_adv_db_d;
  assign w_adv_rel    = ~r_adv_db & r_adv_db_d;
  assign w_set        = (r_state != ST_RUN);

`ifdef TIME_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_to_cnt <= '0;
    end else if (!w_set || w_mode_press || w_adv_press) begin
      r_to_cnt <= '0;
    end else if (i_pulse_n) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = w_set && i_pulse_n && (r_to_cnt == TW'(TIMEOUT - 1))
                     && !w_mode_press && !w_adv_press;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN:     if (w_mode_press) w_next = ST_SET_HR;
      ST_SET_HR:  if (w_mode_press) w_next = ST_SET_MIN;
                  else if (w_timeout) w_next = ST_RUN;
      ST_SET_MIN: if (w_mode_press || w_timeout) w_next = ST_RUN;
      default:    w_next = ST_RUN;
    endcase
  end

  // A MODE press in the same cycle swallows any increment.
  always_comb begin
    w_inc = 1'b0;
    if (w_set && !w_mode_press && !w_timeout) begin
      if (w_adv_press) begin
        w_inc = 1'b1;
      end else if (r_hold_en && r_adv_db) begin
        if (r_hold >= HW'(HOLD_VFAST))     w_inc = i_pulse_vf;
        else if (r_hold >= HW'(HOLD_FAST)) w_inc = i_pulse_f;
      end
    end
  end

  // Auto-repeat is armed only by an ADV press that MODE did not override.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_hold_en <= 1'b0;
      r_hold    <= '0;
    end else if (!w_set || w_mode_press || w_adv_rel || w_timeout) begin
      r_hold_en <= 1'b0;
      r_hold    <= '0;
    end else if (w_adv_press) begin
      r_hold_en <= 1'b1;
      r_hold    <= '0;
    end else if (r_hold_en && i_pulse_n && (r_hold != HW'(HOLD_VFAST))) begin
      r_hold    <= r_hold + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_RUN;
      r_tick    <= 1'b0;
      r_inc_hr  <= 1'b0;
      r_inc_min <= 1'b0;
      r_sec_clr <= 1'b0;
      r_blink   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_tick    <= i_pulse_n && (w_next != ST_SET_MIN);
      r_inc_hr  <= w_inc && (r_state == ST_SET_HR);
      r_inc_min <= w_inc && (r_state == ST_SET_MIN);
      r_sec_clr <= w_mode_press && (r_state == ST_SET_MIN);
      if (w_next == ST_RUN)        r_blink <= 1'b0;
      else if (w_next != r_state)  r_blink <= 1'b1;
      else if (i_pulse_n)          r_blink <= ~r_blink;
    end
  end

  assign o_mode     = r_state;
  assign o_tick_sec = r_tick;
  assign o_inc_hr   = r_inc_hr;
  assign o_inc_min  = r_inc_min;
  assign o_sec_clr  = r_sec_clr;
  assign o_blink    = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: strobes vf/2, f/8, n/32 cycles; HOLD 2/4, TIMEOUT 3.
module tb_time_set_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pv = 1'b0, pf = 1'b0, pn = 1'b0;
  logic       b_mode = 1'b0, b_adv = 1'b0;
  logic       tick, inc_hr, inc_min, sec_clr, blink;
  logic [1:0] mode;

  int total = 0, bad = 0;
  int cyc = 0, sk = 0;
  int n_hr = 0, n_min = 0, n_clr = 0, n_tick_min = 0, n_both = 0, n_tick_bad = 0;
  int q_min[$];

  time_set_ctrl #(.HOLD_FAST(2), .HOLD_VFAST(4), .TIMEOUT(3)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_pulse_vf(pv), .i_pulse_f(pf), .i_pulse_n(pn),
    .i_btn_mode(b_mode), .i_btn_adv(b_adv),
    .o_tick_sec(tick), .o_inc_hr(inc_hr), .o_inc_min(inc_min), .o_sec_clr(sec_clr),
    .o_mode(mode), .o_blink(blink)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    sk = sk + 1;
    pv = (sk % 2 == 0);
    pf = (sk % 8 == 0);
    pn = (sk % 32 == 0);
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (inc_hr) n_hr = n_hr + 1;
      if (inc_min) begin
        n_min = n_min + 1;
        q_min.push_back(cyc);
      end
      if (sec_clr) n_clr = n_clr + 1;
      if (mode == 2'b10 && tick) n_tick_min = n_tick_min + 1;
      if (inc_hr && inc_min) n_both = n_both + 1;
      if (mode == 2'b00 && tick !== pn) n_tick_bad = n_tick_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic align_pn(output int b);
    int lim;
    lim = 0;
    do begin @(posedge clk); #1; lim++; end while (!pn && lim < 100);
    b = cyc;
  endtask

  task automatic press_mode();
    @(negedge clk) b_mode = 1'b1;
    repeat (20) @(negedge clk);
    b_mode = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_inc_hr"}, inc_hr, 0);
    chk({tag, "_inc_min"}, inc_min, 0);
    chk({tag, "_sec_clr"}, sec_clr, 0);
    chk({tag, "_blink"}, blink, 0);
  endtask

  initial begin
    int b, h0, m0, c0;
    rst_n = 1'b0;
    cycles(5);
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    cycles(100);

    c0 = n_clr;
    press_mode();
    chk("cyc_mode1", mode, 1);
    press_mode();
    chk("cyc_mode2", mode, 2);
    chk("cyc_clr_none", n_clr - c0, 0);
    press_mode();
    chk("cyc_mode3", mode, 0);
    chk("cyc_clr_one", n_clr - c0, 1);
    chk("cyc_blink_run", blink, 0);

`ifndef TIME_SET_TIMEOUT_EN
    press_mode();
    chk("dbn_mode", mode, 1);
    h0 = n_hr; m0 = n_min;
    align_pn(b);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) b_adv = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    @(negedge clk) b_adv = 1'b1;
    wait_cyc(b + 68);
    chk("dbn_inc_hr", n_hr - h0, 1);
    chk("dbn_inc_min", n_min - m0, 0);
    @(negedge clk) b_adv = 1'b0;
    cycles(40);
`else
    press_mode();
    chk("sim_pre_mode", mode, 1);
`endif

    h0 = n_hr; m0 = n_min;
    @(negedge clk) begin b_mode = 1'b1; b_adv = 1'b1; end
    cycles(30);
    chk("sim_mode", mode, 2);
    @(negedge clk) b_mode = 1'b0;
    cycles(70);
    chk("sim_inc_hr", n_hr - h0, 0);
    chk("sim_inc_min", n_min - m0, 0);
    @(negedge clk) b_adv = 1'b0;
    cycles(40);

`ifndef TIME_SET_TIMEOUT_EN
    q_min.delete();
    h0 = n_hr;
    c0 = n_clr;
    align_pn(b);
    @(negedge clk) b_adv = 1'b1;
    wait_cyc(b + 200);
    @(negedge clk) b_adv = 1'b0;
    wait_cyc(b + 240);
    chk("hold_count", q_min.size(), 53);
    if (q_min.size() >= 53) begin
      chk("hold_press_t", q_min[0] - b, 17);
      chk("hold_fast_first", q_min[1] - b, 72);
      chk("hold_fast_last", q_min[8] - b, 128);
      chk("hold_vfast_first", q_min[9] - b, 130);
      chk("hold_vfast_last", q_min[52] - b, 216);
    end
    chk("hold_inc_hr", n_hr - h0, 0);
    chk("hold_mode", mode, 2);
    press_mode();
    chk("hold_exit_mode", mode, 0);
    chk("hold_exit_clr", n_clr - c0, 1);
`else
    c0 = n_clr;
    cycles(150);
    chk("sim_timeout_mode", mode, 0);
    chk("sim_timeout_clr", n_clr - c0, 0);
`endif

    press_mode();
    chk("rst_pre_mode", mode, 1);
    @(negedge clk) b_adv = 1'b1;
    cycles(40);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    cycles(3);
    chk_all_zero("rst_hold");
    @(negedge clk) begin b_adv = 1'b0; rst_n = 1'b1; end
    cycles(100);
    chk("rst_after_mode", mode, 0);

    align_pn(b);
    @(negedge clk) b_mode = 1'b1;
    wait_cyc(b + 16);
    chk("to_pre_mode", mode, 0);
    wait_cyc(b + 17);
    chk("to_entry_mode", mode, 1);
    chk("to_entry_blink", blink, 1);
    @(negedge clk) b_mode = 1'b0;
    c0 = n_clr;
    wait_cyc(b + 31);
    chk("to_blink_hold", blink, 1);
    wait_cyc(b + 32);
    chk("to_blink_toggle", blink, 0);
    chk("to_tick_sethr", tick, 1);
`ifdef TIME_SET_TIMEOUT_EN
    wait_cyc(b + 95);
    chk("to_before", mode, 1);
    wait_cyc(b + 96);
    chk("to_return", mode, 0);
    cycles(5);
    chk("to_no_clr", n_clr - c0, 0);
`else
    wait_cyc(b + 160);
    chk("to_persist", mode, 1);
    chk("to_no_clr", n_clr - c0, 0);
`endif

    chk("never_both_inc", n_both, 0);
    chk("tick_run_lag", n_tick_bad, 0);
    chk("tick_setmin", n_tick_min, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
